// File: rtl/secu_pkg.sv
// secu_pkg: shared types and elaboration helpers for the sequential keypad lock.
package secu_pkg;

  // Lock controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    GRANT   = 2'd2,
    LOCKOUT = 2'd3
  } secu_state_t;

  // Larger of two integers; sizes the shared grant/lockout timer.
  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/secu_timer.sv
// secu_timer: loadable down-counter shared by the grant window and the lockout.
// last_o flags the final cycle of a window (count == 1).
module secu_timer #(
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          en_i,
  output logic          last_o
);

  logic [TW-1:0] count_q;

  // Load takes priority over counting; the count parks at zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {TW{1'b0}};
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != {TW{1'b0}})) begin
      count_q <= count_q - TW'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign last_o = (count_q == TW'(1));

endmodule

// File: rtl/secu_lock.sv
// secu_lock: sequential keypad lock. Collects CODE_LEN digits, compares them with a
// snapshot of the stored code taken at the first digit, grants go_o for GO_CYCLES
// clocks on a match, and locks out for LOCK_CYCLES clocks after MAX_TRIES failures.
module secu_lock
  import secu_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 4,
  parameter int MAX_TRIES   = 3,
  parameter int GO_CYCLES   = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [CODE_LEN*DIGIT_W-1:0]       s_i,
  input  logic [DIGIT_W-1:0]                p_i,
  input  logic                              p_valid_i,
  input  logic                              clr_i,
  output logic                              go_o,
  output logic                              stop_o,
  output logic                              err_o,
  output logic                              locked_o,
  output logic [$clog2(MAX_TRIES+1)-1:0]    fail_cnt_o
);

  localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int TW = $clog2(max(GO_CYCLES, LOCK_CYCLES) + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(CODE_LEN - 1);
  localparam logic [FW-1:0] MAX_FAIL  = FW'(MAX_TRIES);
  localparam logic [TW-1:0] GO_LOAD   = TW'(GO_CYCLES);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES);

  // Parameter legality, rejected at elaboration.
  if (DIGIT_W < 1) begin : g_bad_digit_w
    $error("secu_lock: DIGIT_W must be at least 1");
  end
  if (CODE_LEN < 1) begin : g_bad_code_len
    $error("secu_lock: CODE_LEN must be at least 1");
  end
  if (MAX_TRIES < 1) begin : g_bad_max_tries
    $error("secu_lock: MAX_TRIES must be at least 1");
  end
  if (GO_CYCLES < 1) begin : g_bad_go_cycles
    $error("secu_lock: GO_CYCLES must be at least 1");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
    $error("secu_lock: LOCK_CYCLES must be at least 1");
  end

  secu_state_t                    state_q;
  logic [CODE_LEN*DIGIT_W-1:0]    s_q;
  logic [IW-1:0]                  idx_q;
  logic                           mism_q;
  logic [FW-1:0]                  fail_cnt_q;
  logic                           go_q;
  logic                           stop_q;
  logic                           err_q;
  logic                           locked_q;

  logic                           in_idle;
  logic                           in_entry;
  logic [DIGIT_W-1:0]             cur_digit;
  logic                           attempt_mm;
  logic                           final_digit;
  logic                           accept;
  logic                           resolve;
  logic [FW-1:0]                  fail_inc;
  logic                           to_lock;
  logic                           timer_load;
  logic [TW-1:0]                  timer_load_val;
  logic                           timer_en;
  logic                           timer_last;

  // Digit comparison and attempt-resolution decode. The first digit is checked
  // against the live code because the snapshot is only taken on that edge.
  always_comb begin
    in_idle  = (state_q == IDLE);
    in_entry = (state_q == ENTRY);
    if (in_entry) begin
      cur_digit   = s_q[idx_q*DIGIT_W +: DIGIT_W];
      final_digit = (idx_q == LAST_IDX);
    end else begin
      cur_digit   = s_i[DIGIT_W-1:0];
      final_digit = (CODE_LEN == 1);
    end
    attempt_mm     = (p_i != cur_digit) | (in_entry & mism_q);
    accept         = p_valid_i & ~clr_i & (in_idle | in_entry);
    resolve        = accept & final_digit;
    fail_inc       = fail_cnt_q + FW'(1);
    to_lock        = (fail_inc == MAX_FAIL);
    timer_load     = resolve;
    timer_load_val = attempt_mm ? LOCK_LOAD : GO_LOAD;
    timer_en       = (state_q == GRANT) | (state_q == LOCKOUT);
  end

  secu_timer #(
    .TW (TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .en_i       (timer_en),
    .last_o     (timer_last)
  );

  // Lock FSM with registered outputs; err is a single-cycle pulse by default-low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_q        <= {(CODE_LEN*DIGIT_W){1'b0}};
      idx_q      <= {IW{1'b0}};
      mism_q     <= 1'b0;
      fail_cnt_q <= {FW{1'b0}};
      go_q       <= 1'b0;
      stop_q     <= 1'b1;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE, ENTRY: begin
          if (clr_i) begin
            state_q <= IDLE;
            idx_q   <= {IW{1'b0}};
            mism_q  <= 1'b0;
          end else if (p_valid_i) begin
            if (in_idle) begin
              s_q <= s_i;
            end
            mism_q <= attempt_mm;
            if (resolve) begin
              idx_q <= {IW{1'b0}};
              if (!attempt_mm) begin
                state_q    <= GRANT;
                go_q       <= 1'b1;
                stop_q     <= 1'b0;
                fail_cnt_q <= {FW{1'b0}};
              end else begin
                err_q      <= 1'b1;
                fail_cnt_q <= fail_inc;
                if (to_lock) begin
                  state_q  <= LOCKOUT;
                  locked_q <= 1'b1;
                end else begin
                  state_q <= IDLE;
                end
              end
            end else begin
              state_q <= ENTRY;
              idx_q   <= in_idle ? IW'(1) : (idx_q + IW'(1));
            end
          end
        end
        GRANT: begin
          if (clr_i || timer_last) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            stop_q  <= 1'b1;
          end
        end
        LOCKOUT: begin
          if (timer_last) begin
            state_q    <= IDLE;
            locked_q   <= 1'b0;
            fail_cnt_q <= {FW{1'b0}};
          end
        end
        default: begin
          state_q  <= IDLE;
          go_q     <= 1'b0;
          stop_q   <= 1'b1;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign go_o       = go_q;
  assign stop_o     = stop_q;
  assign err_o      = err_q;
  assign locked_o   = locked_q;
  assign fail_cnt_o = fail_cnt_q;

endmodule
